// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle main FSM and the datapath.
// master: the FSM side (drives enables/selects, samples op/zero).
// slave : the datapath side (supplies op/zero, consumes controls).
// dbg_state exposes the FSM state register for observation only.
interface main_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       illegal;
    logic [3:0] dbg_state;

    modport master (
        input  op, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_op, imm_src,
        output illegal, dbg_state
    );

    modport slave (
        output op, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_op, imm_src,
        input  illegal, dbg_state
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle control FSM for the RV32I subset core (lw, sw, R, I-ALU, beq, jal).
// Moore control word is registered alongside the state (computed from the next
// state), so the datapath sees glitch-free selects. Reset loads the FETCH word;
// the write enables are additionally gated by reset so they stay low while it
// is held, and come up as FETCH values the moment it is released.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    main_fsm_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_update;
        logic       branch;
    } ctl_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Moore control word for each state; anything not set is 0.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    state_t w_next_state;
    ctl_t   r_ctl;
    logic   w_op_supported;

    // Opcode legality check used by DECODE.
    always_comb begin
        w_op_supported = 1'b0;
        case (bus.op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: w_op_supported = 1'b1;
            default:                                  w_op_supported = 1'b0;
        endcase
    end

    // Next-state logic; unknown encodings recover to FETCH.
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_JAL:      w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // State register plus registered Moore control word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctl   <= ctl_of(S_FETCH);
        end else begin
            r_state <= w_next_state;
            r_ctl   <= ctl_of(w_next_state);
        end
    end

    // Immediate type follows op in every state, including FETCH.
    always_comb begin
        bus.imm_src = 2'b00;
        case (bus.op)
            OP_SW:   bus.imm_src = 2'b01;
            OP_BEQ:  bus.imm_src = 2'b10;
            OP_JAL:  bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    // zero only matters while the registered word carries branch (BEQ).
    assign bus.pc_write   = ~reset & (r_ctl.pc_update | (r_ctl.branch & bus.zero));
    assign bus.mem_write  = ~reset & r_ctl.mem_write;
    assign bus.ir_write   = ~reset & r_ctl.ir_write;
    assign bus.reg_write  = ~reset & r_ctl.reg_write;
    assign bus.illegal    = ~reset & (r_state == S_DECODE) & ~w_op_supported;
    assign bus.adr_src    = r_ctl.adr_src;
    assign bus.result_src = r_ctl.result_src;
    assign bus.alu_src_a  = r_ctl.alu_src_a;
    assign bus.alu_src_b  = r_ctl.alu_src_b;
    assign bus.alu_op     = r_ctl.alu_op;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: per-instruction vector table with expected event counts,
// hand-written reset sequences, and randomized instruction streams, all
// checked cycle by cycle against an instruction-level model of the controls.
module tb_main_fsm;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    main_fsm_if bus ();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Control word layout: {pc_write, adr_src, mem_write, ir_write, reg_write,
    //   result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], alu_op[1:0], imm_src[1:0], illegal}
    localparam logic [15:0] ENABLE_CLEAR = 16'h47FE;

    function automatic logic [15:0] dut_ctl();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.imm_src, bus.illegal};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return op == 7'h03 || op == 7'h23 || op == 7'h33 ||
               op == 7'h13 || op == 7'h63 || op == 7'h6F;
    endfunction

    // Cycles from FETCH through the last state of the instruction.
    function automatic int inst_len(input logic [6:0] op);
        case (op)
            7'h03:   return 5;
            7'h23:   return 4;
            7'h33:   return 4;
            7'h13:   return 4;
            7'h6F:   return 4;
            7'h63:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected controls for cycle 'step' of instruction inst_op, with op_now on the bus.
    function automatic logic [15:0] model_ctl(input logic [6:0] op_now, input logic [6:0] inst_op,
                                              input int step, input logic z);
        logic       pcw, adr, memw, ir, regw, ill;
        logic [1:0] res, a, b, aop, imm;
        pcw = 0; adr = 0; memw = 0; ir = 0; regw = 0; ill = 0;
        res = 0; a = 0; b = 0; aop = 0;
        case (op_now)
            7'h23:   imm = 2'd1;
            7'h63:   imm = 2'd2;
            7'h6F:   imm = 2'd3;
            default: imm = 2'd0;
        endcase
        if (step == 0) begin
            pcw = 1; ir = 1; res = 2; b = 2;
        end else if (step == 1) begin
            a = 1; b = 1; ill = !is_legal(inst_op);
        end else begin
            case (inst_op)
                7'h03: begin
                    if (step == 2) begin a = 2; b = 1; end
                    else if (step == 3) adr = 1;
                    else begin res = 1; regw = 1; end
                end
                7'h23: begin
                    if (step == 2) begin a = 2; b = 1; end
                    else begin adr = 1; memw = 1; end
                end
                7'h33: begin
                    if (step == 2) begin a = 2; aop = 2; end
                    else regw = 1;
                end
                7'h13: begin
                    if (step == 2) begin a = 2; b = 1; aop = 2; end
                    else regw = 1;
                end
                7'h63: begin
                    a = 2; aop = 1; pcw = z;
                end
                7'h6F: begin
                    if (step == 2) begin a = 1; b = 2; pcw = 1; end
                    else regw = 1;
                end
                default: ;
            endcase
        end
        return {pcw, adr, memw, ir, regw, res, a, b, aop, imm, ill};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One instruction starting just after the edge that entered FETCH.
    // zmode: 0/1 hold zero constant, 2 randomize it every cycle.
    task automatic run_inst(input logic [6:0] op_f, input logic [6:0] op, input int zmode,
                            output int n_pcw, output int n_regw, output int n_memw, output int n_ill);
        logic [6:0] op_now;
        logic [15:0] act;
        n_pcw = 0; n_regw = 0; n_memw = 0; n_ill = 0;
        for (int step = 0; step < inst_len(op); step++) begin
            op_now   = (step == 0) ? op_f : op;
            bus.op   = op_now;
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            @(negedge clk);
            act = dut_ctl();
            check($sformatf("ctl op=%h step=%0d", op, step), act,
                  model_ctl(op_now, op, step, bus.zero));
            n_pcw  += int'(act[15]);
            n_memw += int'(act[13]);
            n_regw += int'(act[11]);
            n_ill  += int'(act[0]);
            @(posedge clk);
            #1;
        end
        check($sformatf("back_in_fetch op=%h", op), {15'd0, bus.ir_write}, 16'd1);
    endtask

    typedef struct {
        logic [6:0] op;
        int         zmode;
        int         pcw;
        int         regw;
        int         memw;
        int         ill;
    } vec_t;

    vec_t vecs[10];
    int   n_pcw, n_regw, n_memw, n_ill;
    logic [6:0] r_op, r_opf;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.op   = 7'h03;
        bus.zero = 1'b0;

        //            op     zmode pcw regw memw ill
        vecs[0] = '{7'h03, 0, 1, 1, 0, 0};  // lw
        vecs[1] = '{7'h23, 1, 1, 0, 1, 0};  // sw, zero high throughout
        vecs[2] = '{7'h33, 1, 1, 1, 0, 0};  // R-type, zero high during ALUWB
        vecs[3] = '{7'h13, 0, 1, 1, 0, 0};  // I-type
        vecs[4] = '{7'h63, 1, 2, 0, 0, 0};  // beq taken
        vecs[5] = '{7'h63, 0, 1, 0, 0, 0};  // beq not taken
        vecs[6] = '{7'h6F, 1, 2, 1, 0, 0};  // jal
        vecs[7] = '{7'h37, 1, 1, 0, 0, 1};  // lui: unsupported
        vecs[8] = '{7'h00, 0, 1, 0, 0, 1};  // all-zero opcode
        vecs[9] = '{7'h13, 1, 1, 1, 0, 0};  // I-type, zero high

        // Reset held: enables low, selects at FETCH values.
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_initial", dut_ctl(), model_ctl(7'h03, 7'h03, 0, 1'b0) & ENABLE_CLEAR);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < 10; i++) begin
            run_inst(vecs[i].op, vecs[i].op, vecs[i].zmode, n_pcw, n_regw, n_memw, n_ill);
            check($sformatf("v%0d pc_write count", i),  16'(n_pcw),  16'(vecs[i].pcw));
            check($sformatf("v%0d reg_write count", i), 16'(n_regw), 16'(vecs[i].regw));
            check($sformatf("v%0d mem_write count", i), 16'(n_memw), 16'(vecs[i].memw));
            check($sformatf("v%0d illegal count", i),   16'(n_ill),  16'(vecs[i].ill));
        end

        // Reset in the middle of MEMREAD of a lw.
        bus.op   = 7'h03;
        bus.zero = 1'b0;
        for (int step = 0; step < 3; step++) begin
            @(negedge clk);
            check($sformatf("pre_reset lw step=%0d", step), dut_ctl(), model_ctl(7'h03, 7'h03, step, 1'b0));
            @(posedge clk);
            #1;
        end
        check("memread_before_reset", dut_ctl(), model_ctl(7'h03, 7'h03, 3, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check("reset_async_mid_memread", dut_ctl(), model_ctl(7'h03, 7'h03, 0, 1'b0) & ENABLE_CLEAR);
        @(posedge clk);
        #1;
        check("reset_hold_across_edge", dut_ctl(), model_ctl(7'h03, 7'h03, 0, 1'b0) & ENABLE_CLEAR);
        reset = 1'b0;
        // First cycle after release is FETCH (ir_write/pc_write high), then DECODE.
        run_inst(7'h03, 7'h03, 0, n_pcw, n_regw, n_memw, n_ill);
        check("post_reset lw pc_write count", 16'(n_pcw), 16'd1);

        // FETCH-time op differs from the real instruction: only imm_src may follow it.
        run_inst(7'h6F, 7'h23, 1, n_pcw, n_regw, n_memw, n_ill);
        run_inst(7'h37, 7'h63, 1, n_pcw, n_regw, n_memw, n_ill);

        // Randomized instruction stream.
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 7))
                0: r_op = 7'h03;
                1: r_op = 7'h23;
                2: r_op = 7'h33;
                3: r_op = 7'h13;
                4: r_op = 7'h63;
                5: r_op = 7'h6F;
                default: r_op = 7'($urandom_range(0, 127));
            endcase
            r_opf = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 127)) : r_op;
            run_inst(r_opf, r_op, 2, n_pcw, n_regw, n_memw, n_ill);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal). Sits directly upstream of the ALU decoder. It sequences each instruction through fetch/decode/execute/memory/writeback cycles, driving datapath enables and mux selects. It also drives the 2-bit `ALUOp` that the ALU decoder combines with funct3/funct7 to form `ALUControl`.

## Interface
Parameters: none.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces state to FETCH.
- `op` input 7: opcode field `instr[6:0]` from the instruction register; valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `pc_write` output 1: PC register enable, equal to `pc_update | (branch & zero)`.
- `adr_src` output 1: memory address mux; 0 = PC, 1 = ALU result register.
- `mem_write` output 1: data memory write enable.
- `ir_write` output 1: instruction register (and OldPC) enable.
- `reg_write` output 1: register file write enable.
- `result_src` output 2: result mux; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` output 2: ALU operand A; 00 = PC, 01 = OldPC, 10 = rs1 register.
- `alu_src_b` output 2: ALU operand B; 00 = rs2 register, 01 = immediate, 10 = constant 4.
- `alu_op` output 2: to the ALU decoder; 00 = add, 01 = subtract, 10 = funct-decoded.
- `imm_src` output 2: immediate type; 00 = I, 01 = S, 10 = B, 11 = J.
- `illegal` output 1: one-cycle pulse in DECODE when `op` is unsupported.

## Operation
- State register uses 4 bits. All outputs are Moore-decoded from state, except `pc_write` (uses `zero`), and `imm_src` and `illegal` (decoded from `op`).
- `imm_src` decodes from `op`: 0000011/0010011 → 00, 0100011 → 01, 1100011 → 10, 1101111 → 11, others → 00.
- Unlisted outputs are 0 in each state. Per-state outputs:
  - FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, alu_op 00, result_src 10, pc_update 1.
  - DECODE: alu_src_a 01, alu_src_b 01, alu_op 00. This precomputes the branch/jump target.
  - MEMADR: alu_src_a 10, alu_src_b 01, alu_op 00.
  - MEMREAD: result_src 00, adr_src 1.
  - MEMWB: result_src 01, reg_write 1.
  - MEMWRITE: result_src 00, adr_src 1, mem_write 1.
  - EXECUTER: alu_src_a 10, alu_src_b 00, alu_op 10.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, alu_op 10.
  - ALUWB: result_src 00, reg_write 1.
  - BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1.
  - JAL: alu_src_a 01, alu_src_b 10, alu_op 00, result_src 00, pc_update 1.
- State transitions:
  - FETCH → DECODE.
  - DECODE branches on `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other value → FETCH with `illegal` = 1
  - MEMADR → MEMREAD if `op[5]` = 0, MEMWRITE if `op[5]` = 1.
  - MEMREAD → MEMWB → FETCH; MEMWRITE → FETCH.
  - EXECUTER, EXECUTEI → ALUWB → FETCH.
  - BEQ → FETCH; JAL → ALUWB.
- Undefined state encodings → FETCH on the next edge.

## Timing
- Cycles per instruction, FETCH through the final state: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- The ALU decoder is combinational, so `alu_op` reaches `ALUControl` in the same cycle.
- Reset:
  - Reset asserted at any time, including mid-instruction, puts state in FETCH immediately (no clock needed).
  - While `reset` = 1: `pc_write`, `ir_write`, `reg_write`, `mem_write`, `illegal` are forced to 0; mux selects hold their FETCH values.
  - The first rising edge after deassertion is the FETCH edge; state is DECODE after it.
- `zero` is sampled only in BEQ. `zero` = 1 in any other state has no effect on `pc_write`.
- `op` changes while in FETCH do not affect outputs other than `imm_src`.

## Test plan
- Reset mid-MEMREAD:
  - Assert `reset` between edges → state = FETCH before the next edge; all enables 0 while reset is high.
  - Release → `ir_write` = 1 and `pc_write` = 1 for exactly one cycle.
- lw (`op` = 0000011):
  - State sequence over 5 edges: FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - `reg_write` = 1 only in cycle 5 with `result_src` = 01; `alu_op` = 00 throughout.
- sw (`op` = 0100011):
  - 4 cycles; `mem_write` = 1 only in cycle 4 with `adr_src` = 1; `imm_src` = 01.
  - `reg_write` is never asserted.
- R-type (`op` = 0110011):
  - `alu_op` = 10 in cycle 3 with `alu_src_b` = 00; `reg_write` = 1 in cycle 4.
  - Repeat with I-type (`op` = 0010011): `alu_src_b` = 01.
- beq (`op` = 1100011), 3 cycles:
  - With `zero` = 1 in cycle 3: `pc_write` = 1 and `alu_op` = 01.
  - With `zero` = 0: `pc_write` = 0. Also hold `zero` = 1 during a FETCH-less ALUWB → `pc_write` stays 0.
- jal (`op` = 1101111) and illegal (`op` = 0110111):
  - jal: `pc_write` = 1 in cycle 3, `reg_write` = 1 in cycle 4.
  - illegal: `illegal` pulses in cycle 2, FETCH follows in cycle 3, no write enables asserted.
